// File: rtl/aes_ctrl_pkg.sv
// Shared encodings for the AES-128 mode controller.
// State, chaining-mode and block-width constants.
package aes_ctrl_pkg;

   localparam int AES_BLK_W = 128;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic MODE_ECB = 1'b0;
   localparam logic MODE_CBC = 1'b1;

endpackage

// File: rtl/aes_mode_ctrl.sv
// ECB/CBC sequencer around a combinational multicycle AES-128 core.
// AES_MODE_CTRL_BLKCNT_EN adds the completed-block counter port blk_count.
module aes_mode_ctrl
   import aes_ctrl_pkg::*;
#(
   parameter int CORE_LAT = 4,
   parameter int CNT_W    = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 mode,
   input  logic                 iv_load,
   input  logic [AES_BLK_W-1:0] iv,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [AES_BLK_W-1:0] in_data,
   input  logic [AES_BLK_W-1:0] in_key,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [AES_BLK_W-1:0] out_data,
   output logic [AES_BLK_W-1:0] core_in,
   output logic [AES_BLK_W-1:0] core_key,
   input  logic [AES_BLK_W-1:0] core_out,
   output logic                 busy
`ifdef AES_MODE_CTRL_BLKCNT_EN
   ,
   output logic [CNT_W-1:0]     blk_count
`endif
);

   state_e                 state_q, state_d;
   logic [7:0]             cnt_q, cnt_d;
   logic                   mode_q, mode_d;
   logic [AES_BLK_W-1:0]   chain_q, chain_d;
   logic [AES_BLK_W-1:0]   cin_q, cin_d;
   logic [AES_BLK_W-1:0]   ckey_q, ckey_d;
   logic [AES_BLK_W-1:0]   odata_q, odata_d;

   assign in_ready  = (state_q == IDLE) & ~iv_load;
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign out_data  = odata_q;
   assign core_in   = cin_q;
   assign core_key  = ckey_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      chain_d = chain_q;
      cin_d   = cin_q;
      ckey_d  = ckey_q;
      odata_d = odata_q;
      unique case (state_q)
         IDLE: begin
            // IV load wins over a block offered in the same cycle
            if (iv_load) begin
               chain_d = iv;
            end else if (in_valid) begin
               cin_d   = in_data ^ ((mode == MODE_CBC) ? chain_q : '0);
               ckey_d  = in_key;
               mode_d  = mode;
               cnt_d   = 8'(CORE_LAT - 1);
               state_d = RUN;
            end
         end
         RUN: begin
            if (cnt_q == 8'd0) begin
               odata_d = core_out;
               if (mode_q == MODE_CBC) chain_d = core_out;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         mode_q  <= MODE_ECB;
         chain_q <= '0;
         cin_q   <= '0;
         ckey_q  <= '0;
         odata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         chain_q <= chain_d;
         cin_q   <= cin_d;
         ckey_q  <= ckey_d;
         odata_q <= odata_d;
      end
   end

`ifdef AES_MODE_CTRL_BLKCNT_EN
   logic [CNT_W-1:0] blk_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blk_q <= '0;
      end else if (out_valid & out_ready) begin
         blk_q <= blk_q + CNT_W'(1);
      end
   end

   assign blk_count = blk_q;
`endif

endmodule

// File: tb/tb_aes_mode_ctrl.sv
// Bench for aes_mode_ctrl with a behavioural AES-128 core on core_in/core_key.
// Known-answer table plus back-pressure, IV/valid collision and reset sequences.
module tb_aes_mode_ctrl;

   localparam int CL = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         mode, iv_load, in_valid, in_ready;
   logic         out_valid, out_ready, busy;
   logic [127:0] iv, in_data, in_key, out_data;
   logic [127:0] core_in, core_key, core_out;
`ifdef AES_MODE_CTRL_BLKCNT_EN
   logic [1:0]   blk_count;
   logic [1:0]   cnt_m;
`endif

   int n_chk  = 0;
   int n_pass = 0;
   logic [127:0] q[$];
   logic [127:0] chain_m;

   always #5 clk = ~clk;

`ifdef AES_MODE_CTRL_BLKCNT_EN
   aes_mode_ctrl #(.CORE_LAT(CL), .CNT_W(2)) dut (
`else
   aes_mode_ctrl #(.CORE_LAT(CL)) dut (
`endif
      .clk(clk), .rst_n(rst_n), .mode(mode), .iv_load(iv_load),
      .iv(iv), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_key(in_key), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .core_in(core_in),
      .core_key(core_key), .core_out(core_out), .busy(busy)
`ifdef AES_MODE_CTRL_BLKCNT_EN
      , .blk_count(blk_count)
`endif
   );

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r, x;
      r = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) r = r ^ x;
         x = xt(x);
      end
      return r;
   endfunction

   // S-box from GF(2^8) inverse (x^254) followed by the affine map
   function automatic logic [7:0] sb(input logic [7:0] x);
      logic [7:0] r;
      r = 8'h01;
      for (int i = 7; i >= 0; i--) begin
         r = gm(r, r);
         if (i != 0) r = gm(r, x);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^
             {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] aes_enc(input logic [127:0] p,
                                            input logic [127:0] k);
      logic [31:0]  w[44];
      logic [7:0]   s[16];
      logic [7:0]   t[16];
      logic [7:0]   rc, a0, a1, a2, a3;
      logic [31:0]  tmp;
      logic [127:0] res;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {sb(tmp[23:16]), sb(tmp[15:8]), sb(tmp[7:0]),
                   sb(tmp[31:24])} ^ {rc, 24'h0};
            rc  = xt(rc);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int i = 0; i < 16; i++)
         s[i] = p[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) t[i] = sb(s[i]);
         for (int c = 0; c < 4; c++)
            for (int w2 = 0; w2 < 4; w2++)
               s[w2+4*c] = t[w2+4*((c+w2)%4)];
         if (r < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
               s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
               s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
               s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
         end
         for (int i = 0; i < 16; i++)
            s[i] = s[i] ^ w[4*r+i/4][31-8*(i%4) -: 8];
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
      return res;
   endfunction

   assign core_out = aes_enc(core_in, core_key);

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic load_iv(input logic [127:0] v);
      @(negedge clk);
      iv_load = 1'b1;
      iv      = v;
      @(posedge clk);
      #1 iv_load = 1'b0;
      chain_m = v;
   endtask

   task automatic send(input logic m, input logic [127:0] k,
                       input logic [127:0] p, input logic [127:0] e);
      int n;
      @(negedge clk);
      mode = m; in_key = k; in_data = p; in_valid = 1'b1;
      #1;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("accept", {127'd0, in_ready}, 128'd1);
      if (in_ready) begin
         @(posedge clk);
         q.push_back(e);
         if (m) chain_m = e;
      end
      #1 in_valid = 1'b0;
   endtask

   task automatic recv(output int lat);
      logic [127:0] e;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 100);
      chk("out_valid_wait", {127'd0, out_valid}, 128'd1);
      e = (q.size() > 0) ? q.pop_front() : 'x;
      chk("out_data", out_data, e);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
`ifdef AES_MODE_CTRL_BLKCNT_EN
      cnt_m = cnt_m + 2'd1;
      chk("blk_count", {126'd0, blk_count}, {126'd0, cnt_m});
`endif
   endtask

   typedef struct {
      logic         ivl;
      logic [127:0] iv;
      logic         m;
      logic [127:0] k;
      logic [127:0] p;
      logic [127:0] exp;
   } vec_t;

   vec_t tbl[5];

   initial begin
      int lat;
      logic [127:0] ka, kb, pv, ivx, hold;
      ka = 128'h000102030405060708090a0b0c0d0e0f;
      kb = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      tbl[0] = '{1'b0, 128'h0, 1'b0, ka,
                 128'h00112233445566778899aabbccddeeff,
                 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
      tbl[1] = '{1'b1, ka, 1'b1, kb,
                 128'h6bc1bee22e409f96e93d7e117393172a,
                 128'h7649abac8119b246cee98e9b12e9197d};
      tbl[2] = '{1'b0, 128'h0, 1'b1, kb,
                 128'hae2d8a571e03ac9c9eb76fac45af8e51,
                 128'h5086cb9b507219ee95db113a917678b2};
      tbl[3] = '{1'b0, 128'h0, 1'b0, kb,
                 128'h6bc1bee22e409f96e93d7e117393172a,
                 128'h3ad77bb40d7a3660a89ecaf32466ef97};
      tbl[4] = '{1'b0, 128'h0, 1'b1, kb,
                 128'h30c81c46a35ce411e5fbc1191a0a52ef,
                 128'h73bed6b8e3c1743b7116e69e22229516};

      rst_n = 1'b1; mode = 1'b0; iv_load = 1'b0; iv = '0;
      in_valid = 1'b0; in_data = '0; in_key = '0; out_ready = 1'b0;
      chain_m = '0;
`ifdef AES_MODE_CTRL_BLKCNT_EN
      cnt_m = 2'd0;
`endif
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
      chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
      chk("rst_busy", {127'd0, busy}, 128'd0);
      chk("rst_out_data", out_data, 128'd0);
      chk("rst_core_in", core_in, 128'd0);
      chk("rst_core_key", core_key, 128'd0);
`ifdef AES_MODE_CTRL_BLKCNT_EN
      chk("rst_blk_count", {126'd0, blk_count}, 128'd0);
`endif
      @(negedge clk) rst_n = 1'b1;

      for (int i = 0; i < 5; i++) begin
         if (tbl[i].ivl) load_iv(tbl[i].iv);
         send(tbl[i].m, tbl[i].k, tbl[i].p, tbl[i].exp);
         recv(lat);
         if (i == 0) chk("latency", 128'(lat), 128'(CL + 1));
      end

      // back-pressure: DONE must hold data while out_ready stays low
      pv = 128'h f69f2445df4f9b17ad2b417be66c3710;
      send(1'b0, kb, pv, aes_enc(pv, kb));
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 100);
      hold = out_data;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         chk("bp_valid", {127'd0, out_valid}, 128'd1);
         chk("bp_data", out_data, hold);
         chk("bp_in_ready", {127'd0, in_ready}, 128'd0);
      end
      recv(lat);
      @(negedge clk);
      chk("bp_idle_busy", {127'd0, busy}, 128'd0);
      chk("bp_idle_ready", {127'd0, in_ready}, 128'd1);

      // iv_load and in_valid together: IV loads, block waits a cycle
      ivx = 128'h0f0e0d0c0b0a09080706050403020100;
      pv  = 128'h00112233445566778899aabbccddeeff;
      mode = 1'b1; in_key = kb; in_data = pv; in_valid = 1'b1;
      iv_load = 1'b1; iv = ivx;
      #1 chk("ivl_in_ready", {127'd0, in_ready}, 128'd0);
      @(posedge clk);
      #1 iv_load = 1'b0;
      chain_m = ivx;
      chk("ivl_not_accepted", {127'd0, busy}, 128'd0);
      send(1'b1, kb, pv, aes_enc(pv ^ chain_m, kb));
      recv(lat);

      // reset in RUN aborts the block and clears the chain
      send(1'b0, ka, pv, aes_enc(pv, ka));
      @(negedge clk);
      chk("run_core_in", core_in, pv);
      chk("run_core_key", core_key, ka);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", {127'd0, out_valid}, 128'd0);
      chk("mid_rst_busy", {127'd0, busy}, 128'd0);
      chk("mid_rst_core_in", core_in, 128'd0);
      chk("mid_rst_core_key", core_key, 128'd0);
      chk("mid_rst_out_data", out_data, 128'd0);
      q.delete();
      chain_m = '0;
`ifdef AES_MODE_CTRL_BLKCNT_EN
      cnt_m = 2'd0;
`endif
      @(negedge clk) rst_n = 1'b1;
      pv = 128'h6bc1bee22e409f96e93d7e117393172a;
      send(1'b1, kb, pv, 128'h3ad77bb40d7a3660a89ecaf32466ef97);
      recv(lat);

      chk("queue_empty", 128'(q.size()), 128'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
